// File: rtl/reg_bank_if.sv
// Purpose : register-file access bundle (one write port, two read ports).
// Latency : carries no state; it only groups signals.
// Backpressure: none; the write strobe is accepted on every clock edge.
interface reg_bank_if #(
  parameter int DATA_W = 32
);
  logic              reg_write;
  logic [4:0]        read_reg1;
  logic [4:0]        read_reg2;
  logic [4:0]        write_reg;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;

  // Datapath side: presents the indices and write-back data, and receives the operands.
  modport master (
    output reg_write, read_reg1, read_reg2, write_reg, write_data,
    input  read_data1, read_data2
  );

  // Register-file side.
  modport slave (
    input  reg_write, read_reg1, read_reg2, write_reg, write_data,
    output read_data1, read_data2
  );
endinterface

// File: rtl/reg_bank.sv
// Purpose : 32 x DATA_W MIPS register file. $0 is hard-wired to zero, and $29 resets to SP_INIT.
// Latency : writes take effect on the next edge; reads are combinational (optionally write-through).
// Backpressure: none; one write can be accepted every cycle.
module reg_bank #(
  parameter int          DATA_W  = 32,
  parameter int unsigned SP_INIT = 227,
  parameter int          BYPASS  = 0
) (
  input  logic       clk,
  input  logic       reset,
  reg_bank_if.slave  bus
);

  localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_INIT);

  // Entry 0 is reset to zero and never written. The read muxes also force it to zero.
  logic [DATA_W-1:0] regs [0:31];

  logic wr_en;
  logic fwd1;
  logic fwd2;

  // A write to index 0 is dropped here.
  // If reg_write is X, the "if" falls through, so storage is not written.
  assign wr_en = bus.reg_write && (bus.write_reg != 5'd0);

  // Storage: reset loads zeros plus the stack pointer, and takes priority over any write on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == 29) ? SP_VAL : '0;
      end
    end else if (wr_en) begin
      regs[bus.write_reg] <= bus.write_data;
    end
  end

  // Write-through forwarding. This only applies when BYPASS is set, and never to index 0.
  assign fwd1 = (BYPASS != 0) && wr_en && (bus.write_reg == bus.read_reg1);
  assign fwd2 = (BYPASS != 0) && wr_en && (bus.write_reg == bus.read_reg2);

  assign bus.read_data1 = (bus.read_reg1 == 5'd0) ? '0 :
                          fwd1 ? bus.write_data : regs[bus.read_reg1];
  assign bus.read_data2 = (bus.read_reg2 == 5'd0) ? '0 :
                          fwd2 ? bus.write_data : regs[bus.read_reg2];

endmodule

// File: tb/tb_reg_bank.sv
// Purpose : directed bench driving identical stimulus into BYPASS=0 and BYPASS=1 register files.
// Latency : checks are sampled 1-2 ns after the rising edge; reset is toggled off the clock grid.
// Backpressure: none; the DUT accepts every write.
module tb_reg_bank;

  localparam int DW = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  reg_bank_if #(.DATA_W(DW)) b0 ();
  reg_bank_if #(.DATA_W(DW)) b1 ();

  reg_bank #(.DATA_W(DW), .SP_INIT(227), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave)
  );
  reg_bank #(.DATA_W(DW), .SP_INIT(227), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );

  // 10 ns clock with rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the same inputs to both register files.
  task automatic drive(input logic we, input logic [4:0] wr, input logic [DW-1:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    b0.reg_write = we;  b1.reg_write = we;
    b0.write_reg = wr;  b1.write_reg = wr;
    b0.write_data = wd; b1.write_data = wd;
    b0.read_reg1 = r1;  b1.read_reg1 = r1;
    b0.read_reg2 = r2;  b1.read_reg2 = r2;
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
    #23 reset = 1'b0;
    step();

    // Preload some state so that the reset has something to clear.
    drive(1'b1, 5'd29, 32'd5, 5'd0, 5'd0);  step();
    drive(1'b1, 5'd3,  32'd7, 5'd3, 5'd29); step();
    drive(1'b0, 5'd0,  '0,    5'd3, 5'd29); #1;
    chk("pre_r3",  b0.read_data1, 32'd7);
    chk("pre_r29", b0.read_data2, 32'd5);

    // Test 1: assert reset asynchronously (t = edge+3), then check it takes effect with no clock edge.
    #1 reset = 1'b1;
    #1;
    chk("async_r3",  b0.read_data1, 32'd0);
    chk("async_r29", b0.read_data2, 32'd227);
    for (int i = 0; i < 32; i++) begin
      b0.read_reg1 = 5'(i); b1.read_reg1 = 5'(i);
      b0.read_reg2 = 5'(31 - i); b1.read_reg2 = 5'(31 - i);
      #1;
      chk($sformatf("rst_p1_b0_%0d", i), b0.read_data1, (i == 29) ? 32'd227 : 32'd0);
      chk($sformatf("rst_p2_b0_%0d", 31 - i), b0.read_data2, (31 - i == 29) ? 32'd227 : 32'd0);
      chk($sformatf("rst_p1_b1_%0d", i), b1.read_data1, (i == 29) ? 32'd227 : 32'd0);
      chk($sformatf("rst_p2_b1_%0d", 31 - i), b1.read_data2, (31 - i == 29) ? 32'd227 : 32'd0);
    end
    #3 reset = 1'b0;
    step();

    // Test 2: write 8, and check that a write with reg_write=0 is ignored.
    drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd8); step();
    drive(1'b0, 5'd10, 32'hDEADBEEF, 5'd8, 5'd8); #1;
    chk("w8_p1_b0", b0.read_data1, 32'hDEADBEEF);
    chk("w8_p2_b0", b0.read_data2, 32'hDEADBEEF);
    chk("w8_p1_b1", b1.read_data1, 32'hDEADBEEF);
    step();
    drive(1'b0, 5'd8, 32'h11111111, 5'd10, 5'd8); step();
    chk("nowr_r10", b0.read_data1, 32'd0);
    chk("nowr_r8",  b0.read_data2, 32'hDEADBEEF);
    chk("nowr_r8_b1", b1.read_data2, 32'hDEADBEEF);

    // Test 3: a write to $0 is discarded and is never forwarded.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0); #1;
    chk("r0_fwd_b0", b0.read_data1, 32'd0);
    chk("r0_fwd_b1", b1.read_data1, 32'd0);
    step();
    drive(1'b0, 5'd0, '0, 5'd0, 5'd0); #1;
    chk("r0_after_b0", b0.read_data1, 32'd0);
    chk("r0_after_b1", b1.read_data1, 32'd0);

    // Test 4: jal writes $31 and the stack writes $29; a reset pulse then restores the reset values.
    drive(1'b1, 5'd31, 32'h00400010, 5'd31, 5'd29); step();
    drive(1'b1, 5'd29, 32'd223,      5'd31, 5'd29); step();
    drive(1'b0, 5'd0,  '0,           5'd31, 5'd29); #1;
    chk("jal_r31", b0.read_data1, 32'h00400010);
    chk("sp_r29",  b0.read_data2, 32'd223);
    chk("sp_r29_b1", b1.read_data2, 32'd223);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    chk("rst_r31", b0.read_data1, 32'd0);
    chk("rst_r29", b0.read_data2, 32'd227);
    chk("rst_r31_b1", b1.read_data1, 32'd0);
    step();

    // Test 5: same-cycle forwarding only happens in the BYPASS=1 instance.
    drive(1'b1, 5'd5, 32'h12345678, 5'd8, 5'd5); #1;
    chk("byp1_r5", b1.read_data2, 32'h12345678);
    chk("byp0_r5", b0.read_data2, 32'd0);
    chk("byp1_other", b1.read_data1, 32'd0);
    step();
    drive(1'b0, 5'd0, '0, 5'd5, 5'd5); #1;
    chk("post_r5_b0", b0.read_data1, 32'h12345678);
    chk("post_r5_b1", b1.read_data2, 32'h12345678);

    // Test 6: reset wins over a write that is pending on the same edge.
    drive(1'b1, 5'd9, 32'hAAAA5555, 5'd9, 5'd9);
    reset = 1'b1;
    step();
    chk("rstwr_r9_b0", b0.read_data1, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("rstwr_r9_b0_pre", b0.read_data2, 32'd0);
    step();
    drive(1'b0, 5'd0, '0, 5'd9, 5'd9); #1;
    chk("rel_r9_b0", b0.read_data1, 32'hAAAA5555);
    chk("rel_r9_b1", b1.read_data2, 32'hAAAA5555);

    // An X on reg_write must not write storage.
    drive(1'bx, 5'd12, 32'h00000001, 5'd12, 5'd12); step();
    drive(1'b0, 5'd0, '0, 5'd12, 5'd12); #1;
    chk("xwe_r12_b0", b0.read_data1, 32'd0);
    chk("xwe_r12_b1", b1.read_data2, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- 32 x 32-bit general-purpose register file for the multicycle MIPS datapath.
- Sits directly downstream of the write-register selector. It consumes the selected 5-bit destination index (rt, 29, 31 or rd) on write_reg, together with write-back data and the RegWrite strobe from the control unit.
- Provides two combinational read ports that feed the A/B operand registers.
- Owns reset initialisation of the stack pointer ($29).

Parameters:
- DATA_W, 32, register and data width in bits.
- SP_INIT, 227, value loaded into register 29 on reset.
- BYPASS, 0. When 1, a same-cycle write is forwarded to the read ports (write-through). When 0, there is no forwarding.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- reg_write  input  1  write enable from control unit.
- read_reg1  input  5  index for read port 1 (instruction[25:21]).
- read_reg2  input  5  index for read port 2 (instruction[20:16]).
- write_reg  input  5  destination index from the write-register selector.
- write_data  input  DATA_W  write-back value.
- read_data1  output  DATA_W  contents of read_reg1.
- read_data2  output  DATA_W  contents of read_reg2.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is asynchronous and active-high (reset).
  - While reset is high, every register is 0 except register 29, which holds SP_INIT. State updates immediately, without waiting for a clock edge.
- Reset values of outputs:
  - read_data1 and read_data2 are combinational from storage.
  - During and after reset they read 0 for every index except 29, which reads SP_INIT (227 = 0x000000E3).
- Write:
  - On the rising clk edge with reset low and reg_write=1, register[write_reg] <= write_data.
  - Write latency is 1 edge. The new value is visible on the read ports in the cycle after the edge.
- Register 0:
  - Hard-wired to zero. Writes to index 0 are discarded with no state change.
  - Reading index 0 always returns 0, in both BYPASS modes.
- Reads:
  - Purely combinational with zero latency.
  - Both ports are independent and may address the same register.
- BYPASS=0: a write and a read of the same index in the same cycle return the old value until the edge.
- BYPASS=1:
  - If reg_write=1, write_reg==read_regN and write_reg!=0, then read_dataN = write_data in the same cycle.
  - Otherwise the port reads from storage.
- reg_write=0: no register changes, whatever write_reg and write_data hold.
- Register 29 and register 31:
  - Ordinary writable registers after reset (jal/stack writes). No special write protection.
- Reset while a write is pending:
  - Reset wins. A write presented on the same edge as an asserted reset is lost.
  - Storage returns to its reset values.
- Reset deasserted: normal writes resume on the first rising edge at which reset is low.
- Unknown/X on reg_write must not corrupt storage in simulation. Treat anything other than 1 as no-write.
- Implementation:
  - Array of 32 DATA_W-bit registers; entry 0 need not be physically stored.
  - One always block with async reset for storage. Continuous assigns for the read muxes and the bypass logic.

Test Plan:
1. Assert reset mid-simulation (not clock-aligned), then read all 32 indices on both ports. Required: 0 everywhere except index 29 = 227; the value appears without a clk edge.
2. reg_write=1, write_reg=8, write_data=0xDEADBEEF, one edge; then read_reg1=8, read_reg2=8. Required: both ports read 0xDEADBEEF. Same write with reg_write=0 leaves 0.
3. reg_write=1, write_reg=0, write_data=0xFFFFFFFF, edge; read_reg1=0. Required: read_data1=0 under both BYPASS=0 and BYPASS=1.
4. Write 31 <- 0x00400010 (jal path), then write 29 <- 223, then pulse reset. Required: reads return 0x00400010 and 223 before the reset pulse, and 0 and 227 after it.
5. BYPASS=1, reg_write=1, write_reg=5, write_data=0x12345678, read_reg2=5, before the edge. Required: read_data2=0x12345678 combinationally. With BYPASS=0 the same stimulus gives the old value (0) until the edge.
6. Reset asserted on the same edge as a write of 9 <- 0xAAAA5555. Required: register 9 reads 0 after reset; a write one edge after deassertion succeeds.
